// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage pipelined immediate field select and sign/zero extension
module imm_extend_pipe #(
  parameter int XLEN = 32,
  parameter int OPW = 4,
  parameter logic [OPW-1:0] OP_J = 4'b1000,
  parameter logic [OPW-1:0] OP_LI = 4'b0010,
  parameter int J_W = 28,
  parameter int LI_W = 23,
  parameter int DEF_W = 18
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] ir_i,
  input  logic            zext_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] data_o,
  output logic [1:0]      fmt_o
);
  logic            s1_valid, s1_zext, s2_valid, s2_adv, fill;
  logic [1:0]      s1_fmt, s2_fmt, fmt_in;
  logic [XLEN-1:0] s1_ir, s2_data, mask, top, ext;
  logic [OPW-1:0]  op;
  int              w;
  always_comb begin
    op = ir_i[XLEN-1 -: OPW];
    fmt_in = op == OP_J ? 2'b10 : op == OP_LI ? 2'b01 : 2'b00;
    s2_adv = !s2_valid | ready_i;
    ready_o = !s1_valid | s2_adv;
    w = s1_fmt == 2'b10 ? J_W : s1_fmt == 2'b01 ? LI_W : DEF_W;
    // a width of XLEN shifts every bit out, leaving an all-ones mask (pass-through)
    mask = ~({XLEN{1'b1}} << w);
    top = XLEN'(1) << (w - 1);
    fill = !s1_zext & |(s1_ir & top);
    ext = (s1_ir & mask) | ({XLEN{fill}} & ~mask);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_zext <= 1'b0;
      s1_fmt <= '0;
      s1_ir <= '0;
      s2_valid <= 1'b0;
      s2_fmt <= '0;
      s2_data <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= ext;
          s2_fmt <= s1_fmt;
        end
      end
      if (ready_o) begin
        s1_valid <= valid_i;
        if (valid_i) begin
          s1_ir <= ir_i;
          s1_fmt <= fmt_in;
          s1_zext <= zext_i;
        end
      end
    end
  end
  assign valid_o = s2_valid;
  assign data_o = s2_data;
  assign fmt_o = s2_fmt;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and random checks of imm_extend_pipe (32-bit and 16-bit pass-through builds)
module tb_imm_extend_pipe;
  logic        clk = 0, rst, flush, valid_i, ready_i, zext;
  logic [31:0] ir, data_o;
  logic [15:0] data16;
  logic [1:0]  fmt_o, fmt16;
  logic        ready_o, valid_o, ready16, valid16;
  int          n_chk = 0, n_fail = 0;
  bit          started = 0, last_acc = 0;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
    .ir_i(ir), .zext_i(zext), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .fmt_o(fmt_o)
  );
  imm_extend_pipe #(.XLEN(16), .J_W(12), .LI_W(8), .DEF_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(ready16),
    .ir_i(ir[15:0]), .zext_i(zext), .valid_o(valid16), .ready_i(ready_i), .data_o(data16), .fmt_o(fmt16)
  );

  typedef struct {
    logic [31:0] d32;
    logic [15:0] d16;
    logic [1:0]  f32;
    logic [1:0]  f16;
    int          age;
  } item_t;
  item_t q[$];

  function automatic logic [31:0] ref_ext(input logic [31:0] word, input bit z, input int xl,
                                          input int jw, input int liw, input int dw, output logic [1:0] f);
    longint unsigned v, field;
    int op, wd;
    v = longint'(word) & ((64'd1 << xl) - 1);
    op = int'(v >> (xl - 4));
    wd = op == 8 ? jw : op == 2 ? liw : dw;
    f = op == 8 ? 2'b10 : op == 2 ? 2'b01 : 2'b00;
    field = v % (64'd1 << wd);
    if (!z && field >= (64'd1 << (wd - 1))) field += (64'd1 << xl) - (64'd1 << wd);
    return field[31:0];
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // queue model: an item becomes visible one edge after acceptance, leaves on out_fire
  always @(posedge clk) begin
    bit r, vo;
    item_t it;
    logic [31:0] t16;
    r = q.size() < 2 || ready_i;
    vo = q.size() > 0 && q[0].age >= 1;
    last_acc = 0;
    if (rst) begin
      q.delete();
      started = 1;
    end else if (flush) q.delete();
    else begin
      if (vo && ready_i) void'(q.pop_front());
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (valid_i && r) begin
        it.d32 = ref_ext(ir, zext, 32, 28, 23, 18, it.f32);
        t16 = ref_ext({16'h0, ir[15:0]}, zext, 16, 12, 8, 16, it.f16);
        it.d16 = t16[15:0];
        it.age = 0;
        q.push_back(it);
        last_acc = 1;
      end
    end
  end

  always @(negedge clk) if (started) begin
    bit vo;
    vo = q.size() > 0 && q[0].age >= 1;
    chk("valid_o", valid_o, vo);
    chk("ready_o", ready_o, q.size() < 2 || ready_i);
    chk("valid16", valid16, vo);
    chk("ready16", ready16, q.size() < 2 || ready_i);
    if (vo) begin
      chk("data_o", data_o, q[0].d32);
      chk("fmt_o", fmt_o, q[0].f32);
      chk("data16", data16, q[0].d16);
      chk("fmt16", fmt16, q[0].f16);
    end
  end

  task automatic drive(input bit v, input logic [31:0] w, input bit z, input bit r, input bit f, input bit rs);
    valid_i = v; ir = w; zext = z; ready_i = r; flush = f; rst = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input logic [31:0] w, input bit z, input logic [31:0] e, input logic [1:0] ef);
    drive(1, w, z, 1, 0, 0);
    step();
    drive(0, w, z, 1, 0, 0);
    @(negedge clk);
    chk({n, "_early"}, valid_o, 0);
    step();
    @(negedge clk);
    chk({n, "_valid"}, valid_o, 1);
    chk({n, "_data"}, data_o, e);
    chk({n, "_fmt"}, fmt_o, ef);
    step();
  endtask

  initial begin
    drive(0, 0, 0, 1, 0, 1);
    repeat (2) step();
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_fmt", fmt_o, 0);
    chk("rst_ready", ready_o, 1);
    step();
    lit("j_sign", 32'h8800_0000, 0, 32'hF800_0000, 2'b10);
    lit("li_sign", 32'h2040_0001, 0, 32'hFFC0_0001, 2'b01);
    lit("li_zero", 32'h2040_0001, 1, 32'h0040_0001, 2'b01);
    lit("def_sign", 32'h3002_0005, 0, 32'hFFFE_0005, 2'b00);
    lit("def_zero", 32'h3002_0005, 1, 32'h0002_0005, 2'b00);
    lit("def_pos", 32'h3001_0005, 0, 32'h0001_0005, 2'b00);
    lit("pass16", 32'h0000_F00F, 0, 32'h0000_F00F, 2'b00);
    chk("pass16_data", data16, 16'hF00F);
    // backpressure: two words fill the pipe, the third waits for ready_i
    drive(1, 32'h2040_0001, 0, 0, 0, 0);
    step();
    drive(1, 32'h8800_0000, 1, 0, 0, 0);
    step();
    drive(1, 32'h3002_0005, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_ready", ready_o, 0);
    chk("bp_valid", valid_o, 1);
    repeat (3) step();
    @(negedge clk);
    chk("bp_hold", data_o, 32'hFFC0_0001);
    drive(1, 32'h3002_0005, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 0);
    repeat (4) step();
    // flush with both stages full and a word offered
    drive(1, 32'h2040_0001, 0, 0, 0, 0);
    step();
    drive(1, 32'h8800_0000, 0, 0, 0, 0);
    step();
    drive(1, 32'h3002_0005, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_valid", valid_o, 0);
    chk("flush_ready", ready_o, 1);
    step();
    lit("post_flush", 32'h3001_0005, 0, 32'h0001_0005, 2'b00);
    // reset mid-stream overriding flush and an offered word
    repeat (3) begin
      drive(1, $urandom, 0, 1, 0, 0);
      step();
    end
    drive(1, 32'h8800_0000, 0, 1, 1, 1);
    step();
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_fmt", fmt_o, 0);
    step();
    lit("post_rst", 32'h8800_0000, 0, 32'hF800_0000, 2'b10);
    for (int i = 0; i < 3000; i++) begin
      if (!valid_i || last_acc) begin
        valid_i = $urandom_range(0, 99) < 70;
        ir = $urandom;
        zext = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) ir[31:28] = $urandom_range(0, 1) ? 4'h8 : 4'h2;
        if ($urandom_range(0, 2) == 0) ir[15:12] = $urandom_range(0, 1) ? 4'h8 : 4'h2;
      end
      ready_i = $urandom_range(0, 99) < 65;
      flush = $urandom_range(0, 99) < 3;
      rst = $urandom_range(0, 299) == 0;
      step();
    end
    drive(0, 0, 0, 1, 0, 0);
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
